// File: rtl/disp_sram_arb.sv
// Display SRAM arbiter: the refresh scanner has priority over the CPU, and a
// starvation guard bounds how many scanner grants can pass a waiting CPU.
module disp_sram_arb #(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_ack,
  output logic [DATA_W-1:0] disp_rdata,
  output logic [ADDR_W-1:0] sram_addr,
  output logic              sram_we,
  output logic [DATA_W-1:0] sram_datao,
  input  logic [DATA_W-1:0] sram_datai,
  input  logic              stat_clr,
  output logic [7:0]        cpu_wait_max
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_ACK   = 2'd3
  } state_e;

  localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);
  localparam logic [7:0] WAIT_LIM   = 8'd255;

  function automatic logic [7:0] sat_inc(input logic [7:0] v, input logic [7:0] lim);
    logic [7:0] r;
    if (v < lim) begin
      r = v + 8'd1;
    end else begin
      r = v;
    end
    return r;
  endfunction

  state_e              state_q, state_d;
  logic                gnt_cpu_q, gnt_cpu_d;
  logic                is_wr_q, is_wr_d;
  logic [7:0]          starve_q, starve_d;
  logic [7:0]          wait_q, wait_d;
  logic [7:0]          wait_max_q, wait_max_d;
  logic [ADDR_W-1:0]   sram_addr_q, sram_addr_d;
  logic                sram_we_q, sram_we_d;
  logic [DATA_W-1:0]   sram_datao_q, sram_datao_d;
  logic                cpu_ack_q, cpu_ack_d;
  logic                disp_ack_q, disp_ack_d;
  logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0]   disp_rdata_q, disp_rdata_d;

  logic disp_win_s;
  logic cpu_grant_s;
  logic cpu_busy_s;

  // The scanner wins unless the CPU is waiting and has already been passed STARVE_MAX times.
  assign disp_win_s  = (state_q == ST_IDLE) && disp_req && (!cpu_req || (starve_q < STARVE_LIM));
  assign cpu_grant_s = (state_q == ST_IDLE) && cpu_req && !disp_win_s;
  assign cpu_busy_s  = (state_q != ST_IDLE) && gnt_cpu_q;

  always_comb begin
    state_d      = state_q;
    gnt_cpu_d    = gnt_cpu_q;
    is_wr_d      = is_wr_q;
    starve_d     = starve_q;
    sram_addr_d  = sram_addr_q;
    sram_we_d    = 1'b0;
    sram_datao_d = sram_datao_q;
    cpu_ack_d    = 1'b0;
    disp_ack_d   = 1'b0;
    cpu_rdata_d  = cpu_rdata_q;
    disp_rdata_d = disp_rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (disp_win_s) begin
          gnt_cpu_d   = 1'b0;
          is_wr_d     = 1'b0;
          sram_addr_d = disp_addr;
          starve_d    = cpu_req ? sat_inc(starve_q, STARVE_LIM) : 8'd0;
          state_d     = ST_ISSUE;
        end else if (cpu_grant_s) begin
          gnt_cpu_d   = 1'b1;
          is_wr_d     = cpu_we;
          sram_addr_d = cpu_addr;
          starve_d    = 8'd0;
          state_d     = ST_ISSUE;
          if (cpu_we) begin
            sram_we_d    = 1'b1;
            sram_datao_d = cpu_wdata;
          end else begin
            sram_we_d    = 1'b0;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        // Only the CPU ever writes, so a write always completes to the CPU.
        if (is_wr_q) begin
          cpu_ack_d = 1'b1;
          state_d   = ST_ACK;
        end else begin
          state_d   = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (gnt_cpu_q) begin
          cpu_rdata_d  = sram_datai;
          cpu_ack_d    = 1'b1;
        end else begin
          disp_rdata_d = sram_datai;
          disp_ack_d   = 1'b1;
        end
        state_d = ST_ACK;
      end
      ST_ACK: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    if (cpu_grant_s) begin
      wait_d = 8'd0;
    end else if (cpu_req && !cpu_busy_s) begin
      wait_d = sat_inc(wait_q, WAIT_LIM);
    end else begin
      wait_d = wait_q;
    end
    // A clear request overrides a maximum update landing in the same cycle.
    if (stat_clr) begin
      wait_max_d = 8'd0;
    end else if (cpu_grant_s && (wait_q > wait_max_q)) begin
      wait_max_d = wait_q;
    end else begin
      wait_max_d = wait_max_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      gnt_cpu_q    <= 1'b0;
      is_wr_q      <= 1'b0;
      starve_q     <= 8'd0;
      wait_q       <= 8'd0;
      wait_max_q   <= 8'd0;
      sram_addr_q  <= '0;
      sram_we_q    <= 1'b0;
      sram_datao_q <= '0;
      cpu_ack_q    <= 1'b0;
      disp_ack_q   <= 1'b0;
      cpu_rdata_q  <= '0;
      disp_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      gnt_cpu_q    <= gnt_cpu_d;
      is_wr_q      <= is_wr_d;
      starve_q     <= starve_d;
      wait_q       <= wait_d;
      wait_max_q   <= wait_max_d;
      sram_addr_q  <= sram_addr_d;
      sram_we_q    <= sram_we_d;
      sram_datao_q <= sram_datao_d;
      cpu_ack_q    <= cpu_ack_d;
      disp_ack_q   <= disp_ack_d;
      cpu_rdata_q  <= cpu_rdata_d;
      disp_rdata_q <= disp_rdata_d;
    end
  end

  assign cpu_ack      = cpu_ack_q;
  assign cpu_rdata    = cpu_rdata_q;
  assign disp_ack     = disp_ack_q;
  assign disp_rdata   = disp_rdata_q;
  assign sram_addr    = sram_addr_q;
  assign sram_we      = sram_we_q;
  assign sram_datao   = sram_datao_q;
  assign cpu_wait_max = wait_max_q;

endmodule

// File: tb/tb_disp_sram_arb.sv
// Bench for disp_sram_arb: directed scenarios plus random traffic checked
// against a transaction-level model of grant order, latency and statistics.
module tb_disp_sram_arb;

  localparam int SM = 4;

  typedef struct {
    logic        we;
    logic [9:0]  addr;
    logic [31:0] data;
  } cpu_tx_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we, cpu_ack, disp_req, disp_ack, sram_we, stat_clr;
  logic [9:0]  cpu_addr, disp_addr, sram_addr;
  logic [31:0] cpu_wdata, cpu_rdata, disp_rdata, sram_datao, sram_datai;
  logic [7:0]  cpu_wait_max;

  logic        s_cpu_req, s_disp_req, s_cpu_ack, s_disp_ack, s_sram_we;
  logic [9:0]  s_sram_addr;
  logic [31:0] s_cpu_rdata, s_disp_rdata, s_sram_datao;
  logic [7:0]  s_wait_max;

  logic [31:0] sram_mem [0:1023];
  logic [31:0] ref_mem  [0:1023];

  int n_checks = 0;
  int n_fails  = 0;

  // model state (values describe the DUT registers in cycle c)
  int c, free_at, starve, wait_cnt, wm;
  int exp_cpu_ack_at, exp_disp_ack_at, exp_we_at, exp_issue_at, cpu_grant_at;
  logic        cpu_pend_rd, exp_issue_we;
  logic [9:0]  exp_issue_addr;
  logic [31:0] cpu_pend_data, disp_pend_data, exp_cpu_rdata, exp_disp_rdata, exp_issue_data;
  int last_cpu_ack_c, last_disp_ack_c, n_cpu_ack, n_disp_ack, disp_since_cpu;

  cpu_tx_t    cpu_q[$];
  logic [9:0] disp_q[$];

  always #5 clk = ~clk;

  disp_sram_arb #(.ADDR_W(10), .DATA_W(32), .STARVE_MAX(SM)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .disp_req(disp_req), .disp_addr(disp_addr), .disp_ack(disp_ack), .disp_rdata(disp_rdata),
    .sram_addr(sram_addr), .sram_we(sram_we), .sram_datao(sram_datao), .sram_datai(sram_datai),
    .stat_clr(stat_clr), .cpu_wait_max(cpu_wait_max)
  );

  disp_sram_arb #(.ADDR_W(10), .DATA_W(32), .STARVE_MAX(255)) dut_sat (
    .clk(clk), .rst(rst),
    .cpu_req(s_cpu_req), .cpu_we(1'b0), .cpu_addr(10'd0), .cpu_wdata(32'd0),
    .cpu_ack(s_cpu_ack), .cpu_rdata(s_cpu_rdata),
    .disp_req(s_disp_req), .disp_addr(10'd0), .disp_ack(s_disp_ack), .disp_rdata(s_disp_rdata),
    .sram_addr(s_sram_addr), .sram_we(s_sram_we), .sram_datao(s_sram_datao), .sram_datai(32'd0),
    .stat_clr(1'b0), .cpu_wait_max(s_wait_max)
  );

  // single-port synchronous-read SRAM
  always @(posedge clk) begin
    if (sram_we) sram_mem[sram_addr] <= sram_datao;
    sram_datai <= sram_mem[sram_addr];
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s @cycle %0d: got 0x%08h expected 0x%08h", tag, c, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cpu_req = 1'b0; disp_req = 1'b0; stat_clr = 1'b0;
    s_cpu_req = 1'b0; s_disp_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    c = 0; free_at = 0; starve = 0; wait_cnt = 0; wm = 0;
    exp_cpu_ack_at = -10; exp_disp_ack_at = -10; exp_we_at = -10;
    exp_issue_at = -10; cpu_grant_at = -10;
    cpu_pend_rd = 1'b0; exp_cpu_rdata = 32'd0; exp_disp_rdata = 32'd0;
    last_cpu_ack_c = -1; last_disp_ack_c = -1; disp_since_cpu = 0;
  endtask

  task automatic check_zero_outputs(input string tag);
    check_eq({tag, "_cpu_ack"},  32'(cpu_ack), 32'd0);
    check_eq({tag, "_disp_ack"}, 32'(disp_ack), 32'd0);
    check_eq({tag, "_sram_we"},  32'(sram_we), 32'd0);
    check_eq({tag, "_sram_addr"}, 32'(sram_addr), 32'd0);
    check_eq({tag, "_sram_datao"}, sram_datao, 32'd0);
    check_eq({tag, "_cpu_rdata"}, cpu_rdata, 32'd0);
    check_eq({tag, "_disp_rdata"}, disp_rdata, 32'd0);
    check_eq({tag, "_wait_max"}, 32'(cpu_wait_max), 32'd0);
  endtask

  // mode 0: random traffic, 1: scripted queues, 2: both requesters always busy
  task automatic step(input int mode, input bit clr);
    cpu_tx_t t;
    bit cpu_now;
    if (c == exp_cpu_ack_at && cpu_pend_rd) exp_cpu_rdata = cpu_pend_data;
    if (c == exp_disp_ack_at) exp_disp_rdata = disp_pend_data;
    check_eq("cpu_ack", 32'(cpu_ack), 32'(c == exp_cpu_ack_at));
    check_eq("disp_ack", 32'(disp_ack), 32'(c == exp_disp_ack_at));
    check_eq("sram_we", 32'(sram_we), 32'(c == exp_we_at));
    check_eq("cpu_rdata", cpu_rdata, exp_cpu_rdata);
    check_eq("disp_rdata", disp_rdata, exp_disp_rdata);
    check_eq("wait_max", 32'(cpu_wait_max), 32'(wm));
    if (c == exp_issue_at) begin
      check_eq("sram_addr", 32'(sram_addr), 32'(exp_issue_addr));
      if (exp_issue_we) check_eq("sram_datao", sram_datao, exp_issue_data);
    end
    if (cpu_ack) begin
      if (mode == 2) check_eq("starve_run", 32'(disp_since_cpu), 32'(SM));
      last_cpu_ack_c = c; n_cpu_ack++; disp_since_cpu = 0;
    end
    if (disp_ack) begin
      last_disp_ack_c = c; n_disp_ack++; disp_since_cpu++;
    end

    if (cpu_req && (c - 1) == exp_cpu_ack_at) cpu_req = 1'b0;
    if (disp_req && (c - 1) == exp_disp_ack_at) disp_req = 1'b0;
    if (!cpu_req) begin
      if ((mode == 0 && $urandom_range(0, 2) == 0) || mode == 2) begin
        cpu_req = 1'b1; cpu_we = 1'($urandom_range(0, 1));
        cpu_addr = 10'($urandom); cpu_wdata = $urandom;
      end else if (mode == 1 && cpu_q.size() > 0) begin
        t = cpu_q.pop_front();
        cpu_req = 1'b1; cpu_we = t.we; cpu_addr = t.addr; cpu_wdata = t.data;
      end
    end
    if (!disp_req) begin
      if ((mode == 0 && $urandom_range(0, 1) == 0) || mode == 2) begin
        disp_req = 1'b1; disp_addr = 10'($urandom);
      end else if (mode == 1 && disp_q.size() > 0) begin
        disp_req = 1'b1; disp_addr = disp_q.pop_front();
      end
    end
    stat_clr = clr || (mode == 0 && $urandom_range(0, 15) == 0);

    cpu_now = 1'b0;
    if (c >= free_at) begin
      if (disp_req && (!cpu_req || starve < SM)) begin
        starve = cpu_req ? starve + 1 : 0;
        disp_pend_data = ref_mem[disp_addr];
        exp_disp_ack_at = c + 3; free_at = c + 4;
        exp_issue_at = c + 1; exp_issue_addr = disp_addr; exp_issue_we = 1'b0;
      end else if (cpu_req) begin
        cpu_now = 1'b1; starve = 0;
        if (wait_cnt > wm) wm = wait_cnt;
        wait_cnt = 0; cpu_grant_at = c;
        exp_issue_at = c + 1; exp_issue_addr = cpu_addr; exp_issue_we = cpu_we;
        if (cpu_we) begin
          ref_mem[cpu_addr] = cpu_wdata; exp_issue_data = cpu_wdata;
          cpu_pend_rd = 1'b0; exp_cpu_ack_at = c + 2; exp_we_at = c + 1; free_at = c + 3;
        end else begin
          cpu_pend_rd = 1'b1; cpu_pend_data = ref_mem[cpu_addr];
          exp_cpu_ack_at = c + 3; free_at = c + 4;
        end
      end
    end
    if (!cpu_now && cpu_req && !(c > cpu_grant_at && c <= exp_cpu_ack_at) && wait_cnt < 255)
      wait_cnt++;
    if (stat_clr) wm = 0;

    @(posedge clk);
    #1;
    c++;
  endtask

  task automatic run(input int n, input int mode, input int clr_at);
    for (int i = 0; i < n; i++) step(mode, i == clr_at);
  endtask

  initial begin
    int p, n0, nd0, nd;
    bit got;
    logic [31:0] kdat;
    cpu_tx_t t;
    for (int i = 0; i < 1024; i++) begin
      sram_mem[i] = 32'(i) ^ 32'hA5A5A5A5;
      ref_mem[i]  = 32'(i) ^ 32'hA5A5A5A5;
    end
    cpu_we = 1'b0; cpu_addr = 10'd0; cpu_wdata = 32'd0; disp_addr = 10'd0;
    n_cpu_ack = 0; n_disp_ack = 0;

    do_reset();
    check_zero_outputs("reset");

    // CPU read of 0x005 interrupted by reset in its WAIT cycle
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h005;
    @(posedge clk); #1;
    check_eq("midrd_issue_addr", 32'(sram_addr), 32'h005);
    @(posedge clk); #1;
    rst = 1'b1; cpu_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    check_zero_outputs("midrd");
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check_eq("midrd_no_ack", 32'(cpu_ack), 32'd0);
    end

    // display-only streaming over the whole preloaded SRAM
    do_reset();
    for (int i = 0; i < 1024; i++) disp_q.push_back(10'(i));
    n0 = n_cpu_ack; nd0 = n_disp_ack;
    run(4100, 1, -1);
    check_eq("stream_disp_acks", 32'(n_disp_ack - nd0), 32'd1024);
    check_eq("stream_cpu_acks", 32'(n_cpu_ack - n0), 32'd0);

    // write 0x3FF then read it back
    t.we = 1'b1; t.addr = 10'h3FF; t.data = 32'hDEADBEEF; cpu_q.push_back(t);
    t.we = 1'b0; cpu_q.push_back(t);
    p = c;
    run(10, 1, -1);
    check_eq("wr_rd_ack_lat", 32'(last_cpu_ack_c - p), 32'd6);
    check_eq("wr_rd_data", cpu_rdata, 32'hDEADBEEF);

    // simultaneous first requests: display first, CPU straight after
    do_reset();
    t.we = 1'b0; t.addr = 10'h020; cpu_q.push_back(t);
    disp_q.push_back(10'h010);
    run(12, 1, -1);
    check_eq("simul_disp_ack_c", 32'(last_disp_ack_c), 32'd3);
    check_eq("simul_cpu_ack_c", 32'(last_cpu_ack_c), 32'd7);
    kdat = 32'hA5A5A5A5 ^ 32'h010;
    check_eq("simul_disp_data", disp_rdata, kdat);
    kdat = 32'hA5A5A5A5 ^ 32'h020;
    check_eq("simul_cpu_data", cpu_rdata, kdat);

    // starvation bound and wait statistic
    do_reset();
    run(200, 2, -1);
    run(12, 1, -1);
    check_eq("wait_max_16", 32'(cpu_wait_max), 32'd16);
    run(3, 1, 0);
    check_eq("wait_max_clr", 32'(cpu_wait_max), 32'd0);

    // random mixed traffic
    run(3000, 0, -1);
    run(12, 1, -1);

    // long stall on the STARVE_MAX=255 instance saturates the wait maximum
    do_reset();
    s_cpu_req = 1'b1; s_disp_req = 1'b1;
    nd = 0; got = 1'b0;
    for (int k = 0; k < 1500 && !got; k++) begin
      @(posedge clk); #1;
      if (s_disp_ack) nd++;
      if (s_cpu_ack) got = 1'b1;
      if (k == 400) check_eq("sat_wait_pre", 32'(s_wait_max), 32'd0);
    end
    check_eq("sat_cpu_ack_seen", 32'(got), 32'd1);
    check_eq("sat_disp_run", 32'(nd), 32'd255);
    check_eq("sat_wait_max", 32'(s_wait_max), 32'd255);
    s_cpu_req = 1'b0; s_disp_req = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
